// File: rtl/vrf_read_sequencer_pkg.sv
// Shared types and field widths for the VRF read sequencer.
package vrf_read_sequencer_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } vrf_read_seq_state_e;

    localparam int VS_W     = 5;
    localparam int OFFSET_W = 3;
    localparam int GROUP_W  = 4;
    localparam int SRC_W    = 4;
    localparam int INST_W   = 3;
    localparam int DATA_W   = 32;

    // Command fields held for the life of one command
    typedef struct packed {
        logic [VS_W-1:0]   vs;
        logic [INST_W-1:0] inst;
        logic [SRC_W-1:0]  src;
    } vrf_read_seq_cmd_t;

    // Register address of a word: base register plus element group, wrapping mod 32
    function automatic logic [VS_W-1:0] vrf_seq_calc_vs(input logic [VS_W-1:0]    base,
                                                        input logic [GROUP_W-1:0] group);
        return base + VS_W'(group);
    endfunction

endpackage

// File: rtl/vrf_read_sequencer.sv
// Per-instruction VRF read sequencer: walks the words of one command, issues
// credit-limited read requests, and forwards returned data with a last flag.
module vrf_read_sequencer
    import vrf_read_sequencer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int WORD_W          = 7
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [VS_W-1:0]     cmd_vs,
    input  logic [INST_W-1:0]   cmd_instructionIndex,
    input  logic [SRC_W-1:0]    cmd_readSource,
    input  logic [WORD_W-1:0]   cmd_lastWord,

    output logic                req_valid,
    input  logic                req_ready,
    output logic [VS_W-1:0]     req_vs,
    output logic [OFFSET_W-1:0] req_offset,
    output logic [GROUP_W-1:0]  req_groupIndex,
    output logic [SRC_W-1:0]    req_readSource,
    output logic [INST_W-1:0]   req_instructionIndex,

    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [DATA_W-1:0]   rsp_bits,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,

    output logic                done_valid,
    output logic [INST_W-1:0]   done_instructionIndex
);

    localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);

    // Control state
    vrf_read_seq_state_e r_state;
    logic                r_done_valid;

    // Per-command state
    vrf_read_seq_cmd_t   r_cmd;
    logic [WORD_W-1:0]   r_last;
    logic [WORD_W-1:0]   r_w;      // next word to issue
    logic [WORD_W-1:0]   r_r;      // next word to return
    logic [CRED_W-1:0]   r_c;      // issued but not yet forwarded

    // Handshake decodes
    logic                w_active;
    logic                w_cmd_fire;
    logic                w_req_fire;
    logic                w_out_fire;
    logic                w_out_last;
    logic                w_has_credit;
    logic [GROUP_W-1:0]  w_group;

    assign w_active     = (r_state != IDLE);
    assign w_has_credit = (r_c < CRED_W'(MAX_OUTSTANDING));
    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_req_fire   = req_valid && req_ready;
    assign w_out_fire   = out_valid && out_ready;
    // The return index is stale outside a command, so last is gated by activity
    assign w_out_last   = w_active && (r_r == r_last);
    assign w_group      = r_w[OFFSET_W +: GROUP_W];

    // Command side
    assign cmd_ready = (r_state == IDLE);

    // Request side: valid never looks at ready; bits only move on fire because
    // credit and index only change on req fire while in ISSUE
    assign req_valid            = (r_state == ISSUE) && w_has_credit;
    assign req_vs               = vrf_seq_calc_vs(r_cmd.vs, w_group);
    assign req_offset           = r_w[OFFSET_W-1:0];
    assign req_groupIndex       = w_group;
    assign req_readSource       = r_cmd.src;
    assign req_instructionIndex = r_cmd.inst;

    // Return data passes straight through; nothing is taken while idle
    assign out_valid = rsp_valid && w_active;
    assign rsp_ready = out_ready && w_active;
    assign out_data  = rsp_bits;
    assign out_last  = w_out_last;

    // Completion pulse; the tag is still latched during the pulse cycle even
    // if a new command is accepted in that same cycle
    assign done_valid            = r_done_valid;
    assign done_instructionIndex = r_cmd.inst;

    // Control FSM with registered completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_done_valid <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) r_state <= ISSUE;
                end
                ISSUE: begin
                    if (w_req_fire && (r_w == r_last)) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_out_fire && w_out_last) begin
                        r_state      <= IDLE;
                        r_done_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latch command fields on acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd  <= '0;
            r_last <= '0;
        end else if (w_cmd_fire) begin
            r_cmd.vs   <= cmd_vs;
            r_cmd.inst <= cmd_instructionIndex;
            r_cmd.src  <= cmd_readSource;
            r_last     <= cmd_lastWord;
        end
    end

    // Issue index: restarts at word 0 per command, advances per request
    always_ff @(posedge clock) begin
        if (reset) begin
            r_w <= '0;
        end else if (w_cmd_fire) begin
            r_w <= '0;
        end else if (w_req_fire) begin
            r_w <= r_w + WORD_W'(1);
        end
    end

    // Return index: restarts at word 0 per command, advances per forwarded word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_r <= '0;
        end else if (w_cmd_fire) begin
            r_r <= '0;
        end else if (w_out_fire) begin
            r_r <= r_r + WORD_W'(1);
        end
    end

    // Credit counter: up on issue, down on forward, unchanged when both fire
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c <= '0;
        end else begin
            case ({w_req_fire, w_out_fire})
                2'b10:   r_c <= r_c + CRED_W'(1);
                2'b01:   r_c <= r_c - CRED_W'(1);
                default: r_c <= r_c;
            endcase
        end
    end

endmodule

// File: doc/vrf_read_sequencer.md
# vrf_read_sequencer

Per-instruction VRF read sequencer that sits directly upstream of the lane's VRF read pipe. It accepts one read command (base register, instruction tag, read source, word count) and walks the element words in order, issuing one read request per word into the read pipe's enqueue port. A credit counter bounds outstanding reads to the pipe's data-queue depth. It forwards returned words downstream with a last flag and pulses completion.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum issued-but-unreturned reads; equals the read pipe's data-queue depth.
- `WORD_W`, default 7: width of the word index and `cmd_lastWord`.

- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `cmd_valid` / `cmd_ready` input / output 1 / 1: command handshake.
- `cmd_vs` input 5: base vector register.
- `cmd_instructionIndex` input 3: instruction tag.
- `cmd_readSource` input 4: read source id.
- `cmd_lastWord` input WORD_W: number of words minus 1 (0..127).
- `req_valid` / `req_ready` output / input 1 / 1: read request handshake toward the read pipe's enqueue port.
- `req_vs` output 5: `cmd_vs + w[6:3]`, mod 32, where `w` is the current word index.
- `req_offset` output 3: `w[2:0]`.
- `req_groupIndex` output 4: `w[6:3]`.
- `req_readSource` output 4: latched `cmd_readSource`.
- `req_instructionIndex` output 3: latched `cmd_instructionIndex`.
- `rsp_valid` / `rsp_ready` input / output 1 / 1: read pipe dequeue handshake.
- `rsp_bits` input 32: returned read data.
- `out_valid` / `out_ready` output / input 1 / 1: downstream data handshake.
- `out_data` output 32: returned word.
- `out_last` output 1: high on the final word of the command.
- `done_valid` output 1: one-cycle completion pulse.
- `done_instructionIndex` output 3: tag of the completed command.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on cmd fire.
  - ISSUE -> DRAIN on the req fire where `w == lastWord`.
  - DRAIN -> IDLE on the out fire where `out_last` is high.
- Per-command registers:
  - Issue index `w`.
  - Return index `r`.
  - Credit count `c`, width `$clog2(MAX_OUTSTANDING+1)`.
  - Latched command fields.
- `cmd_ready = (state==IDLE)`.
- `req_valid = (state==ISSUE) && (c < MAX_OUTSTANDING)`.
  - Must not depend on `req_ready`; the read pipe gates its ready with its own dequeue readiness.
  - Once asserted, `req_valid` and all req bits hold until fire. This is guaranteed because `c` only rises on req fire.
- On req fire: `w++` and `c++`.
- On out fire: `r++` and `c--`.
  - If req fire and out fire occur in the same cycle, `c` is unchanged.
- Data path is a combinational pass-through:
  - `out_valid = rsp_valid && state!=IDLE`.
  - `rsp_ready = out_ready && state!=IDLE`.
  - `out_data = rsp_bits`.
  - `out_last = (r == lastWord)`.
- Returns can arrive in ISSUE state; they are forwarded in order.
- Completion: on the final out fire, the FSM enters IDLE next cycle. In that cycle `done_valid=1` and `done_instructionIndex` = latched tag.
- A new command may be accepted in the same cycle as the done pulse.
- `cmd_lastWord=0` issues exactly one read.
- The 5-bit `vs` addition wraps mod 32.
- A response arriving in IDLE is not accepted (`rsp_ready=0`). This is an upstream protocol violation and is flagged by a bench assertion.

## Timing
- Reset values:
  - state=IDLE, `cmd_ready=1`, `req_valid=0`, `out_valid` follows `rsp_valid` gating (0 in IDLE), `out_last=0`, `done_valid=0`.
  - `w`, `r`, `c` = 0.
- Cmd fire at cycle t: first `req_valid` at t+1 with `w=0`.
- With `req_ready` held at 1 and credits available, one request issues per cycle.
- Read pipe latency is 2 cycles from req fire to data-queue entry, so `out_valid` is earliest at t+4.
- Issue throttles after 4 unreturned reads and resumes the cycle after a return lowers `c`.
- Done pulse comes exactly 1 cycle after the final out fire.
- Reset mid-operation: all state clears next edge and the in-flight command is discarded. The read pipe is reset on the same signal, so no stale responses remain.

## Structure
- Shared package contents:
  - `vrf_read_seq_state_e` (IDLE/ISSUE/DRAIN).
  - Field widths: VS_W=5, OFFSET_W=3, GROUP_W=4, SRC_W=4, INST_W=3.
  - Data width 32.
- Single flat module; no sub-module. The credit counter is inline.

## Test plan
- Cmd vs=3, lastWord=0, inst=5, all readies 1 -> one req (vs=3, offset=0, group=0), one out with `out_last=1`, `done_valid` with inst=5.
- Cmd vs=30, lastWord=17, `req_ready`=1 -> 18 reqs.
  - Word 8: vs=31, group=1, offset=0.
  - Word 16: vs=0 (wrap), group=2, offset=0.
  - `out_last` only on the 18th out.
- lastWord=9 with `rsp_valid` withheld -> exactly 4 reqs fire, then `req_valid=0`. One return -> exactly one further req.
- `req_ready` toggling 1/0 randomly -> req bits stay stable while `req_valid` && !`req_ready`; the word sequence has no gaps.
- `out_ready` held 0 for 10 cycles mid-stream -> no data lost, `c` stays ≤4, order preserved; simultaneous req+out fire leaves `c` unchanged.
- Reset asserted during ISSUE with `c=3` -> next cycle IDLE, `cmd_ready=1`, `req_valid=0`, `c=0`; a following cmd runs cleanly from word 0.
